// File: rtl/pwm_duty_feeder.sv
// Sample FIFO feeding the pwm duty register: converts signed samples to
// offset-binary duty words and applies them only at PWM period boundaries.
module pwm_duty_feeder #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     step,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [N-1:0]             sample_data,
    input  logic [1:0]               volume,
    output logic [N-1:0]             duty,
    output logic                     period_start,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [N-1:0]  DUTY_MID  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  CNT_MAX   = {N{1'b1}};
    localparam logic [N-1:0]  CNT_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    // Attenuate by sign-preserving shift, then flip the MSB to go offset-binary.
    function automatic logic [N-1:0] to_duty(input logic [N-1:0] s, input logic [1:0] v);
        logic signed [N-1:0] sh;
        sh = $signed(s) >>> v;
        to_duty = {~sh[N-1], sh[N-2:0]};
    endfunction

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [N-1:0]  cnt_r;
    logic [N-1:0]  duty_r;
    logic          period_start_r;
    logic          underflow_r;

    logic          step_en_s;
    logic          boundary_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic [LW-1:0] level_nxt_s;
    logic [N-1:0]  cnt_nxt_s;
    logic [N-1:0]  duty_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;

    // Handshake, boundary detection and next-state values.
    always_comb begin
        step_en_s    = step & ena;
        boundary_s   = step_en_s && (cnt_r == CNT_MAX);
        ready_s      = (level_r < LVL_FULL);
        push_s       = sample_valid && ready_s;
        pop_s        = boundary_s && (level_r != LVL_ZERO);
        level_nxt_s  = level_r;
        cnt_nxt_s    = cnt_r;
        duty_nxt_s   = duty_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;

        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // Volume is taken at the pop, so a change mid-period affects the next word.
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            duty_nxt_s   = to_duty(mem_r[rd_ptr_r], volume);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            duty_nxt_s   = duty_r;
        end

        if (step_en_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            level_r        <= LVL_ZERO;
            cnt_r          <= {N{1'b0}};
            duty_r         <= DUTY_MID;
            period_start_r <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            level_r        <= level_nxt_s;
            cnt_r          <= cnt_nxt_s;
            duty_r         <= duty_nxt_s;
            period_start_r <= boundary_s;
            underflow_r    <= boundary_s && !pop_s;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= sample_data;
        end
    end

    assign sample_ready = ready_s;
    assign duty         = duty_r;
    assign period_start = period_start_r;
    assign underflow    = underflow_r;
    assign level        = level_r;

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Directed bench for pwm_duty_feeder with a sample/duty scoreboard.
module tb_pwm_duty_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       step;
    logic       sample_valid;
    logic       sample_ready;
    logic [3:0] sample_data;
    logic [1:0] volume;
    logic [3:0] duty;
    logic       period_start;
    logic       underflow;
    logic [2:0] level;

    int n_vec = 0;
    int n_err = 0;
    int sq[$];     // model FIFO of raw samples (sign-extended)
    int exp_q[$];  // expected duty words awaiting a period_start
    int cnt_m;
    int duty_m;

    pwm_duty_feeder #(.N(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .step(step),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .volume(volume), .duty(duty),
        .period_start(period_start), .underflow(underflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int conv(input int s, input int v);
        int sh;
        sh = s >>> v;
        return (sh + 8) & 15;
    endfunction

    // One clock: drive inputs, advance model, compare outputs 1 ns after the edge.
    task automatic cycle(input bit do_step, input bit do_push, input int s);
        bit exp_ready, bnd, was_empty;
        int d;
        step         = do_step;
        sample_valid = do_push;
        sample_data  = s[3:0];
        exp_ready    = (sq.size() < 4);
        check("ready", sample_ready, exp_ready);
        bnd       = do_step && ena && (cnt_m == 15);
        was_empty = (sq.size() == 0);
        @(posedge clk); #1;
        step         = 1'b0;
        sample_valid = 1'b0;
        if (bnd && !was_empty) begin
            d = conv(sq.pop_front(), int'(volume));
            duty_m = d;
            exp_q.push_back(d);
        end
        if (do_step && ena) cnt_m = (cnt_m + 1) % 16;
        if (do_push && exp_ready) sq.push_back(s);
        check("period_start", period_start, bnd);
        check("underflow", underflow, bnd && was_empty);
        check("level", level, sq.size());
        check("duty", duty, duty_m);
        if (period_start === 1'b1 && underflow !== 1'b1) begin
            check("sb_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("sb_duty", duty, exp_q.pop_front());
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sq.delete();
        exp_q.delete();
        cnt_m  = 0;
        duty_m = 8;
        check("rst_duty", duty, 4'd8);
        check("rst_level", level, 3'd0);
        check("rst_ready", sample_ready, 1'b1);
        check("rst_ps", period_start, 1'b0);
        check("rst_uf", underflow, 1'b0);
    endtask

    initial begin
        int exp_duty[4];
        exp_duty = '{11, 0, 15, 7};
        rst = 1'b1; ena = 1'b1; step = 1'b0; sample_valid = 1'b0;
        sample_data = 4'd0; volume = 2'd0;
        @(posedge clk); #1;

        // 1: reset state, 15 steps do not change duty
        do_reset();
        steps(15);
        check("t1_duty", duty, 4'd8);

        // 2: four samples over four periods
        do_reset();
        cycle(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b1, -8);
        cycle(1'b0, 1'b1, 7);
        cycle(1'b0, 1'b1, -1);
        for (int k = 0; k < 4; k++) begin
            steps(15);
            check("t2_pre_ps", period_start, 1'b0);
            steps(1);
            check("t2_duty", duty, exp_duty[k]);
            check("t2_ps", period_start, 1'b1);
        end

        // 3: full FIFO, refused push coinciding with a pop
        for (int v = 1; v <= 5; v++) cycle(1'b0, 1'b1, v);
        check("t3_full_level", level, 3'd4);
        check("t3_full_ready", sample_ready, 1'b0);
        steps(15);
        cycle(1'b1, 1'b1, 6);
        check("t3_coinc_level", level, 3'd3);
        cycle(1'b0, 1'b1, 6);
        check("t3_refill_level", level, 3'd4);
        steps(64);

        // 4: underflow holds duty; same-cycle push lands next period
        cycle(1'b0, 1'b1, 3);
        steps(16);
        check("t4_duty11", duty, 4'd11);
        steps(15);
        cycle(1'b1, 1'b1, 5);
        check("t4_uf_duty", duty, 4'd11);
        check("t4_uf", underflow, 1'b1);
        check("t4_ps", period_start, 1'b1);
        check("t4_uf_level", level, 3'd1);
        cycle(1'b0, 1'b0, 0);
        check("t4_uf_pulse", underflow, 1'b0);
        steps(16);
        check("t4_next_duty", duty, 4'd13);

        // 5: volume attenuation sampled at the pop
        cycle(1'b0, 1'b1, -8);
        cycle(1'b0, 1'b1, 7);
        cycle(1'b0, 1'b1, -1);
        volume = 2'd1; steps(16); check("t5_vol1", duty, 4'd4);
        volume = 2'd3; steps(16); check("t5_vol3", duty, 4'd8);
        volume = 2'd2; steps(16); check("t5_vol2", duty, 4'd7);
        volume = 2'd0;

        // 6: ena freezes the count; reset mid-period flushes
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, -3);
        steps(10);
        ena = 1'b0;
        steps(20);
        check("t6_hold_level", level, 3'd2);
        check("t6_hold_duty", duty, 4'd7);
        ena = 1'b1;
        steps(5);
        check("t6_no_ps", period_start, 1'b0);
        steps(1);
        check("t6_ps", period_start, 1'b1);
        check("t6_duty", duty, 4'd10);
        cycle(1'b0, 1'b1, 1);
        steps(3);
        check("t6_pre_rst_level", level, 3'd2);
        do_reset();
        steps(16);
        check("t6_flush_uf", underflow, 1'b1);
        check("t6_flush_duty", duty, 4'd8);

        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
